// File: rtl/cordic_scheduler.sv
// Round-robin scheduler sharing one iterative CORDIC among NCH I/Q channels.
// Optional WAIT-state watchdog is compiled in when CORDIC_WDT_EN is defined.
module cordic_scheduler #(
  parameter int unsigned WIDTH   = 42,
  parameter int unsigned NCH     = 4,
  parameter int unsigned CHW     = 2,
  parameter int unsigned TIMEOUT = 1023
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [NCH-1:0]       ch_valid,
  input  logic [NCH*WIDTH-1:0] ch_I,
  input  logic [NCH*WIDTH-1:0] ch_Q,
  input  logic                 clear_overrun,
  output logic                 cordic_valid_in,
  output logic [WIDTH-1:0]     cordic_I,
  output logic [WIDTH-1:0]     cordic_Q,
  input  logic                 cordic_valid_out,
  input  logic [WIDTH-1:0]     cordic_phase,
  input  logic [WIDTH-1:0]     cordic_mag,
  output logic                 res_valid,
  output logic [CHW-1:0]       res_ch,
  output logic [WIDTH-1:0]     res_phase,
  output logic [WIDTH-1:0]     res_mag,
  output logic                 busy,
  output logic [NCH-1:0]       overrun,
  output logic                 timeout_err
);

  typedef enum logic [1:0] {StIdle, StIssue, StWait} state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] slot_i_q [NCH];
  logic [WIDTH-1:0] slot_i_d [NCH];
  logic [WIDTH-1:0] slot_q_q [NCH];
  logic [WIDTH-1:0] slot_q_d [NCH];
  logic [NCH-1:0]   pending_q, pending_d;
  logic [NCH-1:0]   overrun_q, overrun_d;
  logic [CHW-1:0]   rr_ptr_q, rr_ptr_d;
  logic [CHW-1:0]   cur_ch_q, cur_ch_d;
  logic [WIDTH-1:0] cor_i_q, cor_i_d;
  logic [WIDTH-1:0] cor_q_q, cor_q_d;
  logic             cor_vld_q, cor_vld_d;
  logic             res_vld_q, res_vld_d;
  logic [CHW-1:0]   res_ch_q, res_ch_d;
  logic [WIDTH-1:0] res_phase_q, res_phase_d;
  logic [WIDTH-1:0] res_mag_q, res_mag_d;

  logic             gnt_found;
  logic [CHW-1:0]   gnt_idx;
  logic [NCH-1:0]   taken;
  logic             wdt_expired;

  // Cyclic search for the first pending slot at or after rr_ptr_q.
  always_comb begin
    int unsigned    idx;
    logic [CHW-1:0] idx_c;
    idx       = 0;
    idx_c     = '0;
    gnt_found = 1'b0;
    gnt_idx   = '0;
    for (int i = 0; i < NCH; i++) begin
      idx = int'(rr_ptr_q) + i;
      if (idx >= NCH) idx = idx - NCH;
      idx_c = CHW'(idx);
      if (!gnt_found && pending_q[idx_c]) begin
        gnt_found = 1'b1;
        gnt_idx   = idx_c;
      end
    end
  end

  always_comb begin
    state_d     = state_q;
    rr_ptr_d    = rr_ptr_q;
    cur_ch_d    = cur_ch_q;
    cor_i_d     = cor_i_q;
    cor_q_d     = cor_q_q;
    cor_vld_d   = 1'b0;
    res_vld_d   = 1'b0;
    res_ch_d    = res_ch_q;
    res_phase_d = res_phase_q;
    res_mag_d   = res_mag_q;
    taken       = '0;
    slot_i_d    = slot_i_q;
    slot_q_d    = slot_q_q;

    unique case (state_q)
      StIdle: begin
        if (gnt_found) begin
          taken[gnt_idx] = 1'b1;
          cor_i_d        = slot_i_q[gnt_idx];
          cor_q_d        = slot_q_q[gnt_idx];
          cur_ch_d       = gnt_idx;
          rr_ptr_d       = (gnt_idx == CHW'(NCH - 1)) ? '0 : gnt_idx + CHW'(1);
          cor_vld_d      = 1'b1;
          state_d        = StIssue;
        end
      end
      StIssue: state_d = StWait;
      StWait: begin
        if (cordic_valid_out) begin
          res_vld_d   = 1'b1;
          res_ch_d    = cur_ch_q;
          res_phase_d = cordic_phase;
          res_mag_d   = cordic_mag;
          state_d     = StIdle;
        end else if (wdt_expired) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase

    // A slot issued this cycle hands its old value to the CORDIC, so a new
    // sample landing in it is not an overwrite.
    pending_d = (pending_q & ~taken) | ch_valid;
    overrun_d = (clear_overrun ? '0 : overrun_q) | (ch_valid & pending_q & ~taken);
    for (int k = 0; k < NCH; k++) begin
      if (ch_valid[k]) begin
        slot_i_d[k] = ch_I[k*WIDTH +: WIDTH];
        slot_q_d[k] = ch_Q[k*WIDTH +: WIDTH];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q     <= StIdle;
      pending_q   <= '0;
      overrun_q   <= '0;
      rr_ptr_q    <= '0;
      cur_ch_q    <= '0;
      cor_i_q     <= '0;
      cor_q_q     <= '0;
      cor_vld_q   <= 1'b0;
      res_vld_q   <= 1'b0;
      res_ch_q    <= '0;
      res_phase_q <= '0;
      res_mag_q   <= '0;
      for (int k = 0; k < NCH; k++) begin
        slot_i_q[k] <= '0;
        slot_q_q[k] <= '0;
      end
    end else begin
      state_q     <= state_d;
      pending_q   <= pending_d;
      overrun_q   <= overrun_d;
      rr_ptr_q    <= rr_ptr_d;
      cur_ch_q    <= cur_ch_d;
      cor_i_q     <= cor_i_d;
      cor_q_q     <= cor_q_d;
      cor_vld_q   <= cor_vld_d;
      res_vld_q   <= res_vld_d;
      res_ch_q    <= res_ch_d;
      res_phase_q <= res_phase_d;
      res_mag_q   <= res_mag_d;
      slot_i_q    <= slot_i_d;
      slot_q_q    <= slot_q_d;
    end
  end

`ifdef CORDIC_WDT_EN
  localparam int unsigned WdtW = $clog2(TIMEOUT + 1);

  logic [WdtW-1:0] wdt_q, wdt_d;
  logic            timeout_q, timeout_d;

  // wdt_q counts completed WAIT cycles; expiry lands on the TIMEOUT-th one.
  assign wdt_expired = (wdt_q == WdtW'(TIMEOUT - 1));

  always_comb begin
    wdt_d     = wdt_q;
    timeout_d = timeout_q;
    if (state_q == StIssue) begin
      wdt_d = '0;
    end else if (state_q == StWait && !cordic_valid_out) begin
      if (wdt_expired) timeout_d = 1'b1;
      else             wdt_d     = wdt_q + WdtW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      wdt_q     <= '0;
      timeout_q <= 1'b0;
    end else begin
      wdt_q     <= wdt_d;
      timeout_q <= timeout_d;
    end
  end

  assign timeout_err = timeout_q;
`else
  logic unused_timeout;
  assign unused_timeout = ^TIMEOUT;
  assign wdt_expired    = 1'b0;
  assign timeout_err    = 1'b0;
`endif

  assign cordic_valid_in = cor_vld_q;
  assign cordic_I        = cor_i_q;
  assign cordic_Q        = cor_q_q;
  assign res_valid       = res_vld_q;
  assign res_ch          = res_ch_q;
  assign res_phase       = res_phase_q;
  assign res_mag         = res_mag_q;
  assign busy            = (state_q != StIdle);
  assign overrun         = overrun_q;

endmodule
